// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Drains a byte fifo through ren/empty and presents the words on
//               a valid/ready stream, with a 2-entry skid buffer, flush mode
//               and a delivered-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    output logic              fifo_ren,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    input  logic              flush,
    output logic              flush_busy,
    output logic [STAT_W-1:0] words_out
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [1:0]        r_occ;
    logic              r_inflight;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [STAT_W-1:0] r_words_out;
    logic              w_pop;
    logic              w_capture;
    logic [2:0]        w_pending;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides every state
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = c_FLUSH;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (fifo_ren) w_next_state = c_RUN;
                end
                c_RUN: begin
                    if ((r_occ == 2'd0) && !r_inflight && fifo_empty && !fifo_ren)
                        w_next_state = c_IDLE;
                end
                c_FLUSH: begin
                    if (fifo_empty && !r_inflight) w_next_state = c_IDLE;
                end
                default: w_next_state = c_IDLE;
            endcase
        end
    end

    // Outputs; ren looks ahead so buffered + in-flight words never exceed two
    always_comb begin
        flush_busy = (r_state == c_FLUSH);
        m_valid    = (r_occ != 2'd0) && !flush_busy;
        m_data     = (r_occ != 2'd0) ? r_head : '0;
        w_pop      = m_valid & m_ready;
        w_pending  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        fifo_ren   = rst_n & !fifo_empty & (flush_busy | (w_pending < 3'd2));
    end

    assign w_capture = r_inflight & !flush_busy & !flush;
    assign words_out = r_words_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_ren;
        end
    end

    // Skid buffer: r_head is the oldest word, r_tail the second
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else if (flush) begin
            r_occ <= 2'd0;
        end else begin
            case ({w_capture, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= fifo_rdata;
                    else               r_tail <= fifo_rdata;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= fifo_rdata;
                    end else begin
                        r_head <= fifo_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words_out <= '0;
        end else if (w_pop) begin
            r_words_out <= r_words_out + STAT_W'(1);
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_capture && !w_pop && (r_occ == 2'd2)));
    a_occ_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_occ != 2'd3);
    a_no_empty_read: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_ren && fifo_empty));
    a_count_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_empty == (fifo_count == '0));
`endif

endmodule
`default_nettype wire
